// File: rtl/dds_pinc_sched.sv
// rtl/dds_pinc_sched.sv - phase-increment scheduler driving the DDS tuning word
//
// Ports:
//   sys_clk, sys_rst_n  clock (rising edge) and synchronous active-low reset
//   cfg_start           first pinc (sweep) or centre pinc (mod)
//   cfg_step            signed per-step increment (sweep)
//   cfg_dev             deviation around the centre (mod)
//   cfg_nsteps          steps / half-periods per pass
//   cfg_dwell           cycles each pinc value is held
//   cfg_mode            0 = sweep, 1 = square-wave mod
//   cfg_loop            restart the pass automatically
//   start, abort        single-cycle run control
//   pinc, pinc_valid    tuning word and new-value strobe
//   step_idx, mod_phase current step and mod half (0 = +dev)
//   busy, done, err     run active, end-of-pass pulse, rejected-start pulse

module dds_pinc_sched #(
    parameter int PW = 32,
    parameter int NW = 16,
    parameter int DW = 24
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [PW-1:0] cfg_start,
    input  logic [PW-1:0] cfg_step,
    input  logic [PW-1:0] cfg_dev,
    input  logic [NW-1:0] cfg_nsteps,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_mode,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          abort,
    output logic [PW-1:0] pinc,
    output logic          pinc_valid,
    output logic [NW-1:0] step_idx,
    output logic          mod_phase,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [PW-1:0] pinc_n;
    logic          pinc_valid_n;
    logic [NW-1:0] step_idx_n;
    logic          mod_phase_n, busy_n, done_n, err_n;

    // Shadow copy of the configuration taken at a legal start. The sums
    // start+dev and start-dev are formed once here so the run loop never
    // depends on the live cfg_* inputs.
    logic [PW-1:0] sh_first, sh_plus, sh_minus, sh_step;
    logic [PW-1:0] sh_first_n, sh_plus_n, sh_minus_n, sh_step_n;
    logic [NW-1:0] sh_nsteps, sh_nsteps_n;
    logic [DW-1:0] sh_dwell, sh_dwell_n;
    logic          sh_mode, sh_mode_n, sh_loop, sh_loop_n;

    logic [PW-1:0] cfg_plus, cfg_minus;
    logic          last_step;

    assign cfg_plus  = cfg_start + cfg_dev;
    assign cfg_minus = cfg_start - cfg_dev;
    assign last_step = (step_idx == sh_nsteps - NW'(1));

    always_comb begin
        state_n      = state;
        dcnt_n       = dcnt;
        pinc_n       = pinc;
        pinc_valid_n = 1'b0;
        step_idx_n   = step_idx;
        mod_phase_n  = mod_phase;
        busy_n       = busy;
        done_n       = 1'b0;
        err_n        = 1'b0;
        sh_first_n   = sh_first;
        sh_plus_n    = sh_plus;
        sh_minus_n   = sh_minus;
        sh_step_n    = sh_step;
        sh_nsteps_n  = sh_nsteps;
        sh_dwell_n   = sh_dwell;
        sh_mode_n    = sh_mode;
        sh_loop_n    = sh_loop;

        case (state)
            IDLE: begin
                // start together with abort is deliberately a no-op
                if (start && !abort) begin
                    if (cfg_nsteps == '0 || cfg_dwell == '0) begin
                        err_n = 1'b1;
                    end else begin
                        sh_first_n   = cfg_mode ? cfg_plus : cfg_start;
                        sh_plus_n    = cfg_plus;
                        sh_minus_n   = cfg_minus;
                        sh_step_n    = cfg_step;
                        sh_nsteps_n  = cfg_nsteps;
                        sh_dwell_n   = cfg_dwell;
                        sh_mode_n    = cfg_mode;
                        sh_loop_n    = cfg_loop;
                        pinc_n       = cfg_mode ? cfg_plus : cfg_start;
                        pinc_valid_n = 1'b1;
                        step_idx_n   = '0;
                        mod_phase_n  = 1'b0;
                        dcnt_n       = cfg_dwell - DW'(1);
                        busy_n       = 1'b1;
                        state_n      = RUN;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    // park the DDS at zero frequency
                    pinc_n       = '0;
                    pinc_valid_n = 1'b1;
                    step_idx_n   = '0;
                    mod_phase_n  = 1'b0;
                    busy_n       = 1'b0;
                    state_n      = IDLE;
                end else if (dcnt != '0) begin
                    dcnt_n = dcnt - DW'(1);
                end else if (!last_step) begin
                    step_idx_n   = step_idx + NW'(1);
                    dcnt_n       = sh_dwell - DW'(1);
                    pinc_valid_n = 1'b1;
                    if (sh_mode) begin
                        mod_phase_n = ~mod_phase;
                        pinc_n      = mod_phase ? sh_plus : sh_minus;
                    end else begin
                        pinc_n = pinc + sh_step;
                    end
                end else begin
                    done_n = 1'b1;
                    if (sh_loop) begin
                        pinc_n       = sh_first;
                        pinc_valid_n = 1'b1;
                        step_idx_n   = '0;
                        mod_phase_n  = 1'b0;
                        dcnt_n       = sh_dwell - DW'(1);
                    end else begin
                        // pinc keeps the last value so the DDS keeps running
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            dcnt       <= '0;
            pinc       <= '0;
            pinc_valid <= 1'b0;
            step_idx   <= '0;
            mod_phase  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sh_first   <= '0;
            sh_plus    <= '0;
            sh_minus   <= '0;
            sh_step    <= '0;
            sh_nsteps  <= '0;
            sh_dwell   <= '0;
            sh_mode    <= 1'b0;
            sh_loop    <= 1'b0;
        end else begin
            state      <= state_n;
            dcnt       <= dcnt_n;
            pinc       <= pinc_n;
            pinc_valid <= pinc_valid_n;
            step_idx   <= step_idx_n;
            mod_phase  <= mod_phase_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            sh_first   <= sh_first_n;
            sh_plus    <= sh_plus_n;
            sh_minus   <= sh_minus_n;
            sh_step    <= sh_step_n;
            sh_nsteps  <= sh_nsteps_n;
            sh_dwell   <= sh_dwell_n;
            sh_mode    <= sh_mode_n;
            sh_loop    <= sh_loop_n;
        end
    end

endmodule

// File: tb/tb_dds_pinc_sched.sv
// tb/tb_dds_pinc_sched.sv - self-checking bench for dds_pinc_sched

module tb_dds_pinc_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] cfg_start = '0, cfg_step = '0, cfg_dev = '0;
    logic [15:0] cfg_nsteps = '0;
    logic [23:0] cfg_dwell = '0;
    logic        cfg_mode = 1'b0, cfg_loop = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] pinc;
    logic        pinc_valid;
    logic [15:0] step_idx;
    logic        mod_phase, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 sys_clk = ~sys_clk;

    dds_pinc_sched dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg_start (cfg_start),
        .cfg_step  (cfg_step),
        .cfg_dev   (cfg_dev),
        .cfg_nsteps(cfg_nsteps),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .cfg_loop  (cfg_loop),
        .start     (start),
        .abort     (abort),
        .pinc      (pinc),
        .pinc_valid(pinc_valid),
        .step_idx  (step_idx),
        .mod_phase (mod_phase),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Reference model: position in a run is tracked as elapsed edges since
    // the start edge; step k = elapsed / dwell, a new value every dwell edges.
    logic [31:0] m_pinc, m_start, m_step, m_dev;
    logic [15:0] m_idx;
    logic        m_phase, m_busy, m_valid, m_done, m_err, m_mode, m_loop;
    int          m_e, m_n, m_dw;
    bit          m_live = 1'b0;

    task set_step(input int k);
        m_idx   = 16'(k);
        m_phase = m_mode ? k[0] : 1'b0;
        if (m_mode) m_pinc = k[0] ? (m_start - m_dev) : (m_start + m_dev);
        else        m_pinc = m_start + m_step * 32'(k);
        m_valid = 1'b1;
    endtask

    always @(posedge sys_clk) begin
        cyc++;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (!sys_rst_n) begin
            m_busy = 1'b0; m_pinc = '0; m_idx = '0; m_phase = 1'b0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                if (cfg_nsteps == 0 || cfg_dwell == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_start = cfg_start; m_step = cfg_step; m_dev = cfg_dev;
                    m_n = int'(cfg_nsteps); m_dw = int'(cfg_dwell);
                    m_mode = cfg_mode; m_loop = cfg_loop;
                    m_e = 0; m_busy = 1'b1;
                    set_step(0);
                end
            end
        end else if (abort) begin
            m_pinc = '0; m_valid = 1'b1; m_busy = 1'b0; m_idx = '0; m_phase = 1'b0;
        end else begin
            m_e++;
            if (m_e % m_dw == 0) begin
                if (m_e == m_n * m_dw) begin
                    m_done = 1'b1;
                    if (m_loop) begin
                        m_e = 0;
                        set_step(0);
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    set_step(m_e / m_dw);
                end
            end
        end
        m_live = 1'b1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sys_clk) begin
        if (m_live) begin
            n_tests++;
            if ({pinc, pinc_valid, step_idx, mod_phase, busy, done, err} !==
                {m_pinc, m_valid, m_idx, m_phase, m_busy, m_done, m_err}) begin
                n_fail++;
                $display("FAIL model cyc=%0d got pinc=%h v=%b idx=%0d ph=%b busy=%b done=%b err=%b need pinc=%h v=%b idx=%0d ph=%b busy=%b done=%b err=%b",
                         cyc, pinc, pinc_valid, step_idx, mod_phase, busy, done, err,
                         m_pinc, m_valid, m_idx, m_phase, m_busy, m_done, m_err);
            end
        end
    end

    task tick;
        @(posedge sys_clk);
        #1;
    endtask

    task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h need=%h", name, act, exp);
        end
    endtask

    task set_cfg(input logic [31:0] s, input logic [31:0] st, input logic [31:0] d,
                 input logic [15:0] n, input logic [23:0] dw, input logic md, input logic lp);
        cfg_start = s; cfg_step = st; cfg_dev = d;
        cfg_nsteps = n; cfg_dwell = dw; cfg_mode = md; cfg_loop = lp;
    endtask

    task pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_pinc", 64'(pinc), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        sys_rst_n = 1'b1;
        tick();

        // sweep ramp
        set_cfg(32'd43_000_000, 32'd1_000_000, 32'd0, 16'd4, 24'd5, 1'b0, 1'b0);
        pulse_start();
        chk("sweep_t0", 64'(pinc), 64'd43_000_000);
        chk("sweep_t0_valid", 64'(pinc_valid), 64'd1);
        repeat (4) tick();
        chk("sweep_t4_hold", 64'({pinc, pinc_valid}), {31'd0, 32'd43_000_000, 1'b0});
        tick();
        chk("sweep_t5", 64'(pinc), 64'd44_000_000);
        repeat (10) tick();
        chk("sweep_t15", 64'({pinc, step_idx}), {16'd0, 32'd46_000_000, 16'd3});
        repeat (5) tick();
        chk("sweep_done", 64'({done, busy}), 64'b10);
        chk("sweep_hold", 64'(pinc), 64'd46_000_000);
        tick();
        chk("sweep_done_once", 64'(done), 64'd0);

        // square-wave FM
        set_cfg(32'd429_500_000, 32'd0, 32'd100_000, 16'd4, 24'd3, 1'b1, 1'b0);
        pulse_start();
        chk("mod_t0", 64'({pinc, mod_phase}), {31'd0, 32'd429_600_000, 1'b0});
        repeat (3) tick();
        chk("mod_t3", 64'({pinc, mod_phase}), {31'd0, 32'd429_400_000, 1'b1});
        repeat (9) tick();
        chk("mod_done", 64'(done), 64'd1);
        tick();

        // modular wrap both directions
        set_cfg(32'hFFFF_FFF0, 32'h20, 32'd0, 16'd2, 24'd2, 1'b0, 1'b0);
        pulse_start();
        chk("wrap_up_t0", 64'(pinc), 64'hFFFF_FFF0);
        repeat (2) tick();
        chk("wrap_up_t2", 64'(pinc), 64'h0000_0010);
        repeat (3) tick();
        set_cfg(32'h10, 32'hFFFF_FFE0, 32'd0, 16'd2, 24'd2, 1'b0, 1'b0);
        pulse_start();
        repeat (2) tick();
        chk("wrap_down_t2", 64'(pinc), 64'hFFFF_FFF0);
        repeat (3) tick();

        // abort mid-run, then a clean restart
        set_cfg(32'd43_000_000, 32'd1_000_000, 32'd0, 16'd4, 24'd5, 1'b0, 1'b0);
        pulse_start();
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_park", 64'({pinc, pinc_valid, busy}), 64'b010);
        repeat (12) tick();
        pulse_start();
        chk("restart_t0", 64'(pinc), 64'd43_000_000);
        repeat (20) tick();
        chk("restart_done", 64'({done, pinc}), {31'd0, 1'b1, 32'd46_000_000});

        // rejects and ignored requests
        set_cfg(32'd5, 32'd1, 32'd0, 16'd0, 24'd3, 1'b0, 1'b0);
        pulse_start();
        chk("reject_err", 64'({err, busy, pinc}), {30'd0, 2'b10, 32'd46_000_000});
        tick();
        chk("reject_err_once", 64'(err), 64'd0);
        set_cfg(32'd5, 32'd1, 32'd0, 16'd3, 24'd3, 1'b0, 1'b0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'({busy, err}), 64'd0);
        pulse_start();
        repeat (3) tick();
        pulse_start();
        set_cfg($urandom, $urandom, $urandom, 16'd1, 24'd1, 1'b1, 1'b1);
        repeat (12) tick();

        // loop then reset mid-run
        set_cfg(32'd100, 32'd7, 32'd0, 16'd2, 24'd2, 1'b0, 1'b1);
        pulse_start();
        repeat (4) tick();
        chk("loop_done1", 64'({done, busy, pinc}), {30'd0, 2'b11, 32'd100});
        repeat (4) tick();
        chk("loop_done2", 64'({done, busy}), 64'b11);
        tick();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        chk("rst_mid_run", 64'({pinc, step_idx, busy, pinc_valid}), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_cfg($urandom, $urandom, $urandom, 16'($urandom_range(0, 5)),
                        24'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            sys_rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; sys_rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
